pe2_writeback: RTL and testbench

Downstream collector for the PE2 butterfly stage. Accepts the two 24-bit PE2 results per cycle, buffers them in a small FIFO, and writes them to two coefficient memory banks with generated addresses and a ready/valid backpressure handshake. Handles both packed Kyber words (two 12-bit coefficients) and single Dilithium 24-bit coefficients. Signals stage completion to the NTT controller.

---
 rtl/pe2_writeback_pkg.sv | 32 +++
 rtl/pe2_writeback_wb_fifo.sv | 74 +++++++
 rtl/pe2_writeback.sv | 194 +++++++++++++++++++
 tb/tb_pe2_writeback.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe2_writeback_pkg.sv
// pe2_writeback_pkg
//   Shared constants and types for the PE2 writeback collector.
//   - KYBER_Q / DILITHIUM_Q : moduli used by the optional range checker
//   - PAIR_W                : width of one buffered result pair (out3,out4)
//   - wb_state_e            : writeback FSM state encoding
//   - coeff_pair_in_range   : range predicate for one accepted pair
package pe2_writeback_pkg;

    localparam int KYBER_Q     = 3329;
    localparam int DILITHIUM_Q = 8380417;
    localparam int PAIR_W      = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

    // Kyber words carry two packed 12-bit coefficients, so every half is
    // checked; Dilithium words are a single 24-bit coefficient.
    function automatic logic coeff_pair_in_range(input logic        kd_mode,
                                                 input logic [23:0] a,
                                                 input logic [23:0] b);
        if (kd_mode) begin
            return (a < 24'(DILITHIUM_Q)) && (b < 24'(DILITHIUM_Q));
        end
        return (a[23:12] < 12'(KYBER_Q)) && (a[11:0] < 12'(KYBER_Q)) &&
               (b[23:12] < 12'(KYBER_Q)) && (b[11:0] < 12'(KYBER_Q));
    endfunction

endpackage

// File: rtl/pe2_writeback_wb_fifo.sv
// wb_fifo
//   Small synchronous FIFO buffering PE2 result pairs.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     push, push_data     : write a word when not full
//     pop, pop_data       : pop_data shows the head; pop removes it when not empty
//     full, empty         : registered status flags
//   DEPTH must be a power of two (pointers wrap naturally).
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = store[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    // Flags are registered from the next count, so a pop while full only
    // frees the slot from the following cycle on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == (PW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pe2_writeback.sv
// pe2_writeback
//   Collects PE2 butterfly result pairs, buffers them in wb_fifo and writes
//   them to two coefficient banks at consecutive addresses, then pulses done.
//   Ports:
//     clk, rst                      : clock, asynchronous active-low reset
//     start, num_pairs, base_addr,
//     KD_mode                       : pass setup, sampled on start in IDLE
//     in_valid, in_out3, in_out4,
//     in_ready                      : PE2 result input
//     mem_we, mem_ready, mem_addr,
//     mem_wdata0, mem_wdata1        : dual-bank write port
//     busy, done                    : pass status to the NTT controller
//     overflow, range_err           : sticky error flags
//   Handshakes: the input side transfers when in_valid & in_ready at a rising
//   edge; in_valid while in_ready is low drops the pair and sets overflow.
//   The memory side transfers when mem_we & mem_ready at a rising edge;
//   mem_we, mem_addr and the data hold steady until that edge.
//   Optional feature: define PE2_WB_RANGE_CHECK_EN to enable range checking
//   of accepted pairs; otherwise range_err is constant 0.
module pe2_writeback
    import pe2_writeback_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 7,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_pairs,
    input  logic [AW-1:0] base_addr,
    input  logic          KD_mode,
    input  logic          in_valid,
    input  logic [23:0]   in_out3,
    input  logic [23:0]   in_out4,
    output logic          in_ready,
    output logic          mem_we,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [23:0]   mem_wdata0,
    output logic [23:0]   mem_wdata1,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          range_err
);

    wb_state_e         state;
    wb_state_e         state_next;
    logic [CW-1:0]     num_q;
    logic [CW-1:0]     acc_cnt;
    logic [CW-1:0]     wr_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PAIR_W-1:0] fifo_head;
    logic              start_ok;
    logic              accept;
    logic              hs;
    logic              load;
    logic              acc_last;
    logic              wr_last;

    assign start_ok = start & (state == ST_IDLE);
    assign in_ready = (state == ST_RUN) & ~fifo_full;
    assign accept   = in_valid & in_ready;
    assign hs       = mem_we & mem_ready;
    // Refill the output register when it is empty or being written this edge,
    // which gives one write per cycle with mem_ready held high.
    assign load     = ~fifo_empty & (~mem_we | hs);
    assign acc_last = (acc_cnt == num_q - 1'b1);
    assign wr_last  = (wr_cnt == num_q - 1'b1);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (PAIR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (accept),
        .push_data ({in_out3, in_out4}),
        .pop       (load),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_pairs == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && acc_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (hs && wr_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            num_q    <= '0;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            mem_addr <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                num_q    <= num_pairs;
                acc_cnt  <= '0;
                wr_cnt   <= '0;
                mem_addr <= base_addr;
            end else begin
                if (accept) begin
                    acc_cnt <= acc_cnt + 1'b1;
                end
                if (hs) begin
                    wr_cnt   <= wr_cnt + 1'b1;
                    mem_addr <= mem_addr + 1'b1;
                end
            end
            // A pair dropped in the same cycle as the clearing start still
            // counts as an overflow.
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end else if (start_ok) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we     <= 1'b0;
            mem_wdata0 <= '0;
            mem_wdata1 <= '0;
        end else begin
            if (load) begin
                mem_we     <= 1'b1;
                mem_wdata0 <= fifo_head[47:24];
                mem_wdata1 <= fifo_head[23:0];
            end else if (hs) begin
                mem_we <= 1'b0;
            end
        end
    end

`ifdef PE2_WB_RANGE_CHECK_EN
    logic kd_q;
    logic range_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kd_q        <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                kd_q <= KD_mode;
            end
            if (accept && !coeff_pair_in_range(kd_q, in_out3, in_out4)) begin
                range_err_q <= 1'b1;
            end else if (start_ok) begin
                range_err_q <= 1'b0;
            end
        end
    end

    assign range_err = range_err_q;
`else
    // Mode only steers range checking, so it has no consumer in this build.
    logic unused_kd_mode;
    assign unused_kd_mode = KD_mode;
    assign range_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pe2_writeback.sv
module tb_pe2_writeback;

    localparam int DEPTH = 4;
    localparam int AW    = 7;
    localparam int CW    = 8;
    localparam int AMOD  = 1 << AW;
    localparam int EW    = AW + 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_pairs;
    logic [AW-1:0] base_addr;
    logic          KD_mode;
    logic          in_valid;
    logic [23:0]   in_out3;
    logic [23:0]   in_out4;
    logic          in_ready;
    logic          mem_we;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata0;
    logic [23:0]   mem_wdata1;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          range_err;

    always #5 clk = ~clk;

    pe2_writeback #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_pairs  (num_pairs),
        .base_addr  (base_addr),
        .KD_mode    (KD_mode),
        .in_valid   (in_valid),
        .in_out3    (in_out3),
        .in_out4    (in_out4),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata0 (mem_wdata0),
        .mem_wdata1 (mem_wdata1),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .range_err  (range_err)
    );

    // Scoreboard: expected writes {addr, wdata0, wdata1} in order.
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    bit            exp_ovf;
    bit            exp_rerr;
    bit            use_first;
    logic [23:0]   first_o3;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference range rule written directly from the moduli.
    function automatic bit value_ok(input bit mode, input logic [23:0] v);
        int iv;
        iv = int'(v);
        if (mode) return iv < 8380417;
        return ((iv / 4096) < 3329) && ((iv % 4096) < 3329);
    endfunction

    function automatic logic [23:0] gen_value(input bit mode);
        if ($urandom_range(1, 10) == 1) return 24'($urandom);
        if (mode) return 24'($urandom_range(0, 8380416));
        return {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
    endfunction

    // One complete pass. stall_until > 0 holds mem_ready low for that many
    // cycles and checks the buffer capacity at its end; inject drives a pair
    // while in_ready is low at that point. exp_done_at > 0 checks the cycle
    // (counted from the start edge) at which done is seen.
    task automatic run_pass(input int n, input int base, input bit mode,
                            input int vprob, input int rprob,
                            input int stall_until, input bit inject,
                            input int exp_done_at);
        int            k;
        int            sent;
        int            done_k;
        bit            stall_prev;
        logic [EW-1:0] held;
        logic [23:0]   o3;
        logic [23:0]   o4;

        @(negedge clk);
        start     = 1'b1;
        num_pairs = CW'(n);
        base_addr = AW'(base);
        KD_mode   = mode;
        in_valid  = 1'b0;
        exp_ovf   = 1'b0;
        exp_rerr  = 1'b0;
        exp_q.delete();
        k          = 0;
        sent       = 0;
        done_k     = 0;
        stall_prev = 1'b0;
        held       = '0;

        while (done_k == 0 && k < 400) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (stall_until > 0 && k <= stall_until) mem_ready = 1'b0;
            else mem_ready = ($urandom_range(1, 100) <= rprob);

            in_valid = 1'b0;
            if (sent < n && in_ready && $urandom_range(1, 100) <= vprob) begin
                o3 = (use_first && sent == 0) ? first_o3 : gen_value(mode);
                o4 = gen_value(mode);
                in_valid = 1'b1;
                in_out3  = o3;
                in_out4  = o4;
                exp_q.push_back({AW'((base + sent) % AMOD), o3, o4});
                if (!value_ok(mode, o3) || !value_ok(mode, o4)) begin
`ifdef PE2_WB_RANGE_CHECK_EN
                    exp_rerr = 1'b1;
`endif
                end
                sent++;
            end else if (inject && k == stall_until && !in_ready) begin
                in_valid = 1'b1;
                in_out3  = 24'hBAD0BA;
                in_out4  = 24'h0BAD0B;
                exp_ovf  = 1'b1;
            end
            #1;

            if (k == 1) begin
                check_eq("busy_after_start", busy, 1);
                check_eq("overflow_cleared_by_start", overflow, 0);
            end
            if (stall_until > 0 && k == stall_until) begin
                check_eq("stall_accepted_pairs", sent, DEPTH + 1);
                check_eq("stall_in_ready_low", in_ready, 0);
            end
            if (stall_prev) begin
                check_eq("mem_hold_stable", {mem_we, mem_addr, mem_wdata0, mem_wdata1}, {1'b1, held});
            end
            if (mem_we && mem_ready) begin
                if (exp_q.size() == 0) check_eq("spurious_write", mem_we, 0);
                else check_eq("write", {mem_addr, mem_wdata0, mem_wdata1}, exp_q.pop_front());
            end
            stall_prev = mem_we && !mem_ready;
            held       = {mem_addr, mem_wdata0, mem_wdata1};
            if (done) done_k = k;
        end

        check_eq("done_seen", done, 1);
        check_eq("all_writes_before_done", exp_q.size(), 0);
        check_eq("overflow_end", overflow, exp_ovf);
        check_eq("range_err_end", range_err, exp_rerr);
        if (exp_done_at > 0) check_eq("done_latency", done_k, exp_done_at);
        if (n == 0) check_eq("zero_pass_done_quick", done_k <= 2, 1);

        @(negedge clk);
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("done_single_pulse", done, 0);
        check_eq("busy_dropped", busy, 0);
        check_eq("idle_in_ready", in_ready, 0);
        check_eq("idle_no_we", mem_we, 0);
        use_first = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        num_pairs = '0;
        base_addr = '0;
        KD_mode   = 1'b0;
        in_valid  = 1'b0;
        in_out3   = '0;
        in_out4   = '0;
        mem_ready = 1'b1;
        use_first = 1'b0;
        first_o3  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_wdata0", mem_wdata0, 0);
        check_eq("rst_wdata1", mem_wdata1, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_range_err", range_err, 0);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back pass: writes at 10..13, done one cycle after last write
        run_pass(4, 10, 1'b0, 100, 100, 0, 1'b0, 7);

        // Address wrap 126,127,0,1
        run_pass(4, 126, 1'b1, 100, 100, 0, 1'b0, 0);

        // Empty pass
        run_pass(0, 33, 1'b0, 100, 100, 0, 1'b0, 0);

        // Memory stall with a dropped pair while full
        run_pass(8, 50, 1'b0, 100, 100, 6, 1'b1, 0);

        // Next start clears overflow (checked at cycle 1 of this pass)
        run_pass(3, 0, 1'b1, 100, 100, 0, 1'b0, 0);

        // Pair driven while IDLE is dropped
        @(negedge clk);
        in_valid = 1'b1;
        in_out3  = 24'h123456;
        in_out4  = 24'h654321;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("idle_drop_overflow", overflow, 1);
        check_eq("idle_drop_no_we", mem_we, 0);

        // Kyber high half equal to q, then Dilithium value just below q
        use_first = 1'b1;
        first_o3  = 24'hD01000;
        run_pass(2, 70, 1'b0, 100, 100, 0, 1'b0, 0);
        use_first = 1'b1;
        first_o3  = 24'h7FE000;
        run_pass(2, 80, 1'b1, 100, 100, 0, 1'b0, 0);

        // Randomized passes
        for (int p = 0; p < 25; p++) begin
            run_pass($urandom_range(1, 12), $urandom_range(0, AMOD - 1), 1'($urandom_range(0, 1)),
                     $urandom_range(40, 100), $urandom_range(30, 100), 0, 1'b0, 0);
        end

        // Reset in the middle of a pass
        @(negedge clk);
        start     = 1'b1;
        num_pairs = CW'(8);
        base_addr = AW'(5);
        mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_out3  = 24'($urandom);
            in_out4  = 24'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_mem_we", mem_we, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_eq("midrst_no_write", mem_we, 0);
        end

        // Normal pass after the aborted one
        run_pass(5, 100, 1'b0, 80, 70, 0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
